// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, shift-command bit positions and flag indices
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOT  = 3'b101,
    OP_INC  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

  // Per-operand shift command bit positions
  localparam int CMD_LEFT    = 0;  // 0 = right, 1 = left
  localparam int CMD_CIRC    = 1;  // 0 = linear, 1 = circular
  localparam int CMD_NOSHIFT = 2;  // 1 = bypass the shifter

  // Flag vector indices
  localparam int FLAG_C    = 0;
  localparam int FLAG_Z    = 1;
  localparam int FLAG_N    = 2;
  localparam int FLAG_V    = 3;
  localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/alu_barrel_shift.sv
// rtl/alu_barrel_shift.sv - combinational linear/circular operand shifter
module alu_barrel_shift #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       cmd,
  input  logic [SHW-1:0]   amount,
  output logic [WIDTH-1:0] result
);
  import alu_pkg::*;

  localparam int RW = $clog2(WIDTH);

  logic [31:0]      amt_ext;
  logic [RW-1:0]    rot_amt;
  logic [RW-1:0]    rot_right_amt;
  logic [WIDTH-1:0] rotated;

  // Rotation distance wraps modulo WIDTH; a left rotate is a right rotate by WIDTH-r.
  assign amt_ext       = 32'(amount);
  assign rot_amt       = amt_ext[RW-1:0];
  assign rot_right_amt = cmd[CMD_LEFT] ? (~rot_amt + RW'(1)) : rot_amt;
  assign rotated       = (data >> rot_right_amt) | (data << (32'(WIDTH) - 32'(rot_right_amt)));

  // Select bypass, rotate, or linear shift with zero fill
  always_comb begin
    result = data;
    if (!cmd[CMD_NOSHIFT] && (amt_ext != 32'd0)) begin
      if (cmd[CMD_CIRC]) begin
        result = rotated;
      end else if (amt_ext >= 32'(WIDTH)) begin
        result = '0;
      end else if (cmd[CMD_LEFT]) begin
        result = data << amt_ext;
      end else begin
        result = data >> amt_ext;
      end
    end
  end

endmodule

// File: rtl/alu_pipe_datapath.sv
// rtl/alu_pipe_datapath.sv - two-stage shift/ALU pipeline with valid/ready handshake
module alu_pipe_datapath #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             iClock,
  input  logic             iResetN,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic [2:0]       iRegACommand,
  input  logic [2:0]       iRegBCommand,
  input  logic [SHW-1:0]   iShiftAmount,
  input  logic [2:0]       iAluOpcode,
  input  logic             iUseAcc,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oAccumulator,
  output logic             oCarryFlag,
  output logic             oZeroFlag,
  output logic             oNegFlag,
  output logic             oOverflowFlag
);
  import alu_pkg::*;

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0]     a_shifted;
  logic [WIDTH-1:0]     b_shifted;
  logic                 s1_valid;
  logic [WIDTH-1:0]     s1_a;
  logic [WIDTH-1:0]     s1_b;
  alu_op_e              s1_op;
  logic                 s1_use_acc;
  logic                 transfer;
  logic                 load2;
  logic [WIDTH-1:0]     alu_b;
  logic [WIDTH:0]       ext_res;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_carry;
  logic                 alu_ovf;
  logic [NUM_FLAGS-1:0] alu_flags;
  logic [NUM_FLAGS-1:0] flags_q;

  alu_barrel_shift #(.WIDTH(WIDTH), .SHW(SHW)) u_shift_a (
    .data   (iA),
    .cmd    (iRegACommand),
    .amount (iShiftAmount),
    .result (a_shifted)
  );

  alu_barrel_shift #(.WIDTH(WIDTH), .SHW(SHW)) u_shift_b (
    .data   (iB),
    .cmd    (iRegBCommand),
    .amount (iShiftAmount),
    .result (b_shifted)
  );

  // Stage 2 advances whenever it holds nothing or its result is being consumed
  assign load2    = s1_valid && (!oValid || iReady);
  assign oReady   = !s1_valid || load2;
  assign transfer = iValid && oReady;

  // Accumulate mode reads the current output register, so chained ops never stall
  assign alu_b = s1_use_acc ? oAccumulator : s1_b;

  // ALU result with carry/no-borrow and signed overflow
  always_comb begin
    ext_res   = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (s1_op)
      OP_ADD: begin
        ext_res   = {1'b0, s1_a} + {1'b0, alu_b};
        alu_res   = ext_res[WIDTH-1:0];
        alu_carry = ext_res[WIDTH];
        alu_ovf   = (s1_a[MSB] == alu_b[MSB]) && (alu_res[MSB] != s1_a[MSB]);
      end
      OP_SUB: begin
        ext_res   = {1'b0, s1_a} - {1'b0, alu_b};
        alu_res   = ext_res[WIDTH-1:0];
        alu_carry = !ext_res[WIDTH];
        alu_ovf   = (s1_a[MSB] != alu_b[MSB]) && (alu_res[MSB] != s1_a[MSB]);
      end
      OP_AND:  alu_res = s1_a & alu_b;
      OP_OR:   alu_res = s1_a | alu_b;
      OP_XOR:  alu_res = s1_a ^ alu_b;
      OP_NOT:  alu_res = ~s1_a;
      OP_INC: begin
        ext_res   = {1'b0, s1_a} + (WIDTH+1)'(1);
        alu_res   = ext_res[WIDTH-1:0];
        alu_carry = ext_res[WIDTH];
        alu_ovf   = !s1_a[MSB] && alu_res[MSB];
      end
      OP_PASS: alu_res = alu_b;
      default: alu_res = '0;
    endcase
  end

  // Pack flags in package index order
  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_C] = alu_carry;
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_N] = alu_res[MSB];
    alu_flags[FLAG_V] = alu_ovf;
  end

  // Stage 1: capture shifted operands and control on transfer
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= OP_ADD;
      s1_use_acc <= 1'b0;
    end else if (transfer) begin
      s1_valid   <= 1'b1;
      s1_a       <= a_shifted;
      s1_b       <= b_shifted;
      s1_op      <= alu_op_e'(iAluOpcode);
      s1_use_acc <= iUseAcc;
    end else if (load2) begin
      s1_valid   <= 1'b0;
    end
  end

  // Stage 2: load result and flags, hold them under backpressure
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      oValid       <= 1'b0;
      oAccumulator <= '0;
      flags_q      <= '0;
    end else if (load2) begin
      oValid       <= 1'b1;
      oAccumulator <= alu_res;
      flags_q      <= alu_flags;
    end else if (iReady) begin
      oValid       <= 1'b0;
    end
  end

  assign oCarryFlag    = flags_q[FLAG_C];
  assign oZeroFlag     = flags_q[FLAG_Z];
  assign oNegFlag      = flags_q[FLAG_N];
  assign oOverflowFlag = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_pipe_datapath.sv
// tb/tb_alu_pipe_datapath.sv - self-checking bench for alu_pipe_datapath
module tb_alu_pipe_datapath;

  localparam int W  = 16;
  localparam int SW = 4;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    ca;
    logic [2:0]    cb;
    logic [SW-1:0] amt;
    logic [2:0]    op;
    logic          ua;
  } req_t;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;  // {C, Z, N, V}
  } exp_t;

  typedef struct {
    req_t rq;
    exp_t ex;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          out_ready_dut;
  logic [W-1:0]  in_a, in_b;
  logic [2:0]    cmd_a, cmd_b;
  logic [SW-1:0] amount;
  logic [2:0]    opcode;
  logic          use_acc;
  logic          out_valid;
  logic          down_ready;
  logic [W-1:0]  acc;
  logic          c_flag, z_flag, n_flag, v_flag;
  logic [3:0]    flags;

  int checks = 0;
  int errors = 0;
  int consumed = 0;
  exp_t expq[$];
  logic [W-1:0] model_acc;

  assign flags = {c_flag, z_flag, n_flag, v_flag};

  always #5 clk = ~clk;

  alu_pipe_datapath #(.WIDTH(W), .SHW(SW)) dut (
    .iClock        (clk),
    .iResetN       (rst_n),
    .iValid        (in_valid),
    .oReady        (out_ready_dut),
    .iA            (in_a),
    .iB            (in_b),
    .iRegACommand  (cmd_a),
    .iRegBCommand  (cmd_b),
    .iShiftAmount  (amount),
    .iAluOpcode    (opcode),
    .iUseAcc       (use_acc),
    .oValid        (out_valid),
    .iReady        (down_ready),
    .oAccumulator  (acc),
    .oCarryFlag    (c_flag),
    .oZeroFlag     (z_flag),
    .oNegFlag      (n_flag),
    .oOverflowFlag (v_flag)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Reference shifter from the command rules, using arithmetic and bit loops
  function automatic logic [W-1:0] shift_ref(input logic [W-1:0] v, input logic [2:0] cmd, input int amt);
    logic [W-1:0] o;
    longint x;
    int r;
    x = longint'(v);
    o = '0;
    if (cmd[2] || amt == 0) return v;
    if (cmd[1]) begin
      r = amt % W;
      for (int i = 0; i < W; i++) begin
        if (cmd[0]) o[(i + r) % W] = v[i];
        else        o[i] = v[(i + r) % W];
      end
      return o;
    end
    if (amt >= W) return '0;
    if (cmd[0]) return W'((x * (longint'(1) << amt)) % (longint'(1) << W));
    return W'(x / (longint'(1) << amt));
  endfunction

  // Reference ALU using unsigned/signed integer arithmetic
  function automatic exp_t alu_ref(input req_t q, input logic [W-1:0] acc_in);
    longint m, h, ua, ub, sa, sb, full, s, res;
    logic c, v;
    exp_t e;
    m = longint'(1) << W;
    h = longint'(1) << (W - 1);
    ua = longint'(shift_ref(q.a, q.ca, int'(q.amt)));
    ub = q.ua ? longint'(acc_in) : longint'(shift_ref(q.b, q.cb, int'(q.amt)));
    sa = (ua >= h) ? ua - m : ua;
    sb = (ub >= h) ? ub - m : ub;
    c = 1'b0;
    v = 1'b0;
    res = 0;
    case (q.op)
      3'd0: begin full = ua + ub; res = full % m; c = (full >= m); s = sa + sb; v = (s >= h) || (s < -h); end
      3'd1: begin res = (ua - ub + m) % m; c = (ua >= ub); s = sa - sb; v = (s >= h) || (s < -h); end
      3'd2: res = ua & ub;
      3'd3: res = ua | ub;
      3'd4: res = ua ^ ub;
      3'd5: res = m - 1 - ua;
      3'd6: begin full = ua + 1; res = full % m; c = (full >= m); s = sa + 1; v = (s >= h); end
      default: res = ub;
    endcase
    e.res = W'(res);
    e.flg = {c, (res == 0), (res >= h), v};
    return e;
  endfunction

  task automatic drive(input logic v, input req_t q, input logic rdy);
    in_valid   = v;
    in_a       = q.a;
    in_b       = q.b;
    cmd_a      = q.ca;
    cmd_b      = q.cb;
    amount     = q.amt;
    opcode     = q.op;
    use_acc    = q.ua;
    down_ready = rdy;
  endtask

  // One cycle from a falling edge: drive, score any consumed result, record any transfer
  task automatic step(input logic v, input req_t q, input logic rdy, output logic accepted);
    exp_t e;
    drive(v, q, rdy);
    #1;
    accepted = v && out_ready_dut;
    if (out_valid && rdy) begin
      consumed++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: actual %0h required none", acc);
      end else begin
        e = expq.pop_front();
        chk("sb_result", acc, e.res);
        chk("sb_flags", W'(flags), W'(e.flg));
      end
    end
    if (accepted) begin
      e = alu_ref(q, model_acc);
      model_acc = e.res;
      expq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    expq.delete();
    model_acc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic req_t mkreq(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] ca,
                                 input logic [2:0] cb, input logic [SW-1:0] amt, input logic [2:0] op,
                                 input logic ua);
    req_t q;
    q.a = a; q.b = b; q.ca = ca; q.cb = cb; q.amt = amt; q.op = op; q.ua = ua;
    return q;
  endfunction

  function automatic vec_t mkv(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] ca,
                               input logic [2:0] cb, input logic [SW-1:0] amt, input logic [2:0] op,
                               input logic [W-1:0] res, input logic [3:0] flg);
    vec_t t;
    t.rq = mkreq(a, b, ca, cb, amt, op, 1'b0);
    t.ex.res = res;
    t.ex.flg = flg;
    return t;
  endfunction

  function automatic req_t rand_req();
    return mkreq(W'($urandom), W'($urandom), 3'($urandom), 3'($urandom), SW'($urandom),
                 3'($urandom), ($urandom_range(0, 3) == 0));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[16];
    req_t reqs[4];
    req_t q;
    logic a_ok;
    logic [W-1:0] first_res;
    int idx;
    int n_acc;

    vecs[0]  = mkv(16'hFFFF, 16'h0001, 3'b100, 3'b100, 4'd0,  3'd0, 16'h0000, 4'b1100);
    vecs[1]  = mkv(16'h8000, 16'h0001, 3'b100, 3'b100, 4'd0,  3'd1, 16'h7FFF, 4'b1001);
    vecs[2]  = mkv(16'h0001, 16'h0002, 3'b100, 3'b100, 4'd0,  3'd1, 16'hFFFF, 4'b0010);
    vecs[3]  = mkv(16'h8001, 16'h0000, 3'b011, 3'b100, 4'd1,  3'd3, 16'h0003, 4'b0000);
    vecs[4]  = mkv(16'h8001, 16'h0000, 3'b001, 3'b100, 4'd1,  3'd3, 16'h0002, 4'b0000);
    vecs[5]  = mkv(16'hF0F0, 16'h3C3C, 3'b100, 3'b100, 4'd0,  3'd2, 16'h3030, 4'b0000);
    vecs[6]  = mkv(16'hAAAA, 16'hAAAA, 3'b100, 3'b100, 4'd0,  3'd4, 16'h0000, 4'b0100);
    vecs[7]  = mkv(16'h00FF, 16'h0000, 3'b100, 3'b100, 4'd0,  3'd5, 16'hFF00, 4'b0010);
    vecs[8]  = mkv(16'h7FFF, 16'h0000, 3'b100, 3'b100, 4'd0,  3'd6, 16'h8000, 4'b0011);
    vecs[9]  = mkv(16'hFFFF, 16'h1234, 3'b100, 3'b100, 4'd0,  3'd7, 16'h1234, 4'b0000);
    vecs[10] = mkv(16'h8000, 16'h0000, 3'b000, 3'b100, 4'd15, 3'd3, 16'h0001, 4'b0000);
    vecs[11] = mkv(16'h0001, 16'h0000, 3'b010, 3'b100, 4'd4,  3'd3, 16'h1000, 4'b0000);
    vecs[12] = mkv(16'h0000, 16'h0001, 3'b100, 3'b001, 4'd15, 3'd7, 16'h8000, 4'b0010);
    vecs[13] = mkv(16'h1234, 16'h0000, 3'b111, 3'b100, 4'd5,  3'd3, 16'h1234, 4'b0000);
    vecs[14] = mkv(16'hFFFF, 16'h0000, 3'b100, 3'b100, 4'd0,  3'd6, 16'h0000, 4'b1100);
    vecs[15] = mkv(16'h0005, 16'h0005, 3'b100, 3'b100, 4'd0,  3'd1, 16'h0000, 4'b1100);

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, mkreq('0, '0, 3'b100, 3'b100, '0, 3'd0, 1'b0), 1'b1);
    model_acc = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", W'(out_valid), '0);
    chk("rst_acc", acc, '0);
    chk("rst_flags", W'(flags), '0);
    chk("rst_ready", W'(out_ready_dut), W'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("ready_after_release", W'(out_ready_dut), W'(1));
    @(negedge clk);

    // Directed vectors: each one isolated, result checked two cycles after transfer
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vecs[i].rq, 1'b1);
      #1;
      chk("vec_ready", W'(out_ready_dut), W'(1));
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("vec_latency1", W'(out_valid), '0);
      @(negedge clk);
      #1;
      chk("vec_valid", W'(out_valid), W'(1));
      chk($sformatf("vec%0d_result", i), acc, vecs[i].ex.res);
      chk($sformatf("vec%0d_flags", i), W'(flags), W'(vecs[i].ex.flg));
      @(negedge clk);
    end

    // Accumulate stream: four back-to-back ADDs of 1 into the accumulator
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(k < 4, mkreq(16'h0001, W'($urandom), 3'b100, 3'b100, 4'd0, 3'd0, 1'b1), 1'b1);
      #1;
      if (k < 4) chk("stream_ready", W'(out_ready_dut), W'(1));
      if (k >= 2) begin
        chk("stream_valid", W'(out_valid), W'(1));
        chk("stream_result", acc, W'(k - 1));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Backpressure: three requests offered while downstream stalls
    do_reset();
    for (int k = 0; k < 4; k++) reqs[k] = mkreq(W'($urandom), W'($urandom), 3'b100, 3'b100, 4'd0, 3'd0, 1'b0);
    idx = 0;
    n_acc = 0;
    consumed = 0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, reqs[idx], 1'b0, a_ok);
      if (a_ok) begin idx++; n_acc++; end
    end
    chk("bp_accepted", W'(n_acc), W'(2));
    #1;
    chk("bp_ready_low", W'(out_ready_dut), '0);
    chk("bp_valid_held", W'(out_valid), W'(1));
    first_res = acc;
    chk("bp_first_result", acc, expq[0].res);
    step(1'b1, reqs[idx], 1'b0, a_ok);
    if (a_ok) idx++;
    chk("bp_first_stable", acc, first_res);
    for (int k = 0; k < 20 && !(idx == 3 && expq.size() == 0); k++) begin
      step(idx < 3, reqs[idx], 1'b1, a_ok);
      if (a_ok) idx++;
    end
    chk("bp_all_accepted", W'(idx), W'(3));
    chk("bp_queue_empty", W'(expq.size()), '0);
    chk("bp_consumed", W'(consumed), W'(3));

    // Randomized traffic against the reference model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      q = rand_req();
      step($urandom_range(0, 2) != 0, q, $urandom_range(0, 9) < 7, a_ok);
    end
    for (int k = 0; k < 20 && expq.size() != 0; k++) begin
      step(1'b0, q, 1'b1, a_ok);
    end
    chk("rand_drained", W'(expq.size()), '0);

    // Reset with both stages full discards everything in flight
    q = mkreq(16'h1111, 16'h2222, 3'b100, 3'b100, 4'd0, 3'd0, 1'b0);
    step(1'b1, q, 1'b0, a_ok);
    step(1'b1, q, 1'b0, a_ok);
    #1;
    chk("full_ready_low", W'(out_ready_dut), '0);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_valid", W'(out_valid), '0);
    chk("midrst_acc", acc, '0);
    chk("midrst_flags", W'(flags), '0);
    chk("midrst_ready", W'(out_ready_dut), W'(1));
    expq.delete();
    model_acc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, mkreq(16'h0005, 16'hFFFF, 3'b100, 3'b100, 4'd0, 3'd0, 1'b1), 1'b1);
    #1;
    chk("post_rst_ready", W'(out_ready_dut), W'(1));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("post_rst_latency1", W'(out_valid), '0);
    @(negedge clk);
    #1;
    chk("post_rst_valid", W'(out_valid), W'(1));
    chk("post_rst_result", acc, 16'h0005);
    chk("post_rst_flags", W'(flags), '0);
    @(negedge clk);
    #1;
    chk("post_rst_cleared", W'(out_valid), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe_datapath.md
ALU_PIPE_DATAPATH -- requirements
Module: alu_pipe_datapath

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width (min 4, power of 2).
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 iClock  in  1  single clock, all state on rising edge.
REQ-004 iResetN  in  1  asynchronous, active-low reset.
REQ-005 iValid  in  1  upstream request valid.
REQ-006 oReady  out  1  block accepts request this cycle.
REQ-007 iA, iB  in  WIDTH each  raw operands.
REQ-008 iRegACommand, iRegBCommand  in  3 each  per-operand shift command: bit2=1 no shift; bit1 0=linear/1=circular; bit0 0=right/1=left.
REQ-009 iShiftAmount  in  SHW  shift distance shared by both operands.
REQ-010 iAluOpcode  in  3  operation select.
REQ-011 iUseAcc  in  1  1 = operand B replaced by current oAccumulator at execute.
REQ-012 oValid  out  1  result valid; iReady  in  1  downstream accepts result.
REQ-013 oAccumulator  out  WIDTH  registered result.
REQ-014 oCarryFlag, oZeroFlag, oNegFlag, oOverflowFlag  out  1 each  registered flags.

Function
REQ-015 Transfer occurs when iValid && oReady; all request inputs sampled only then.
REQ-016 Stage 1 (operand): on transfer, shifted iA/iB and opcode/iUseAcc captured into operand registers; s1 valid set.
REQ-017 Linear shift fills vacated bits with 0; circular rotates; amount 0 or bit2=1 passes operand unchanged; amount >= WIDTH on linear shift yields 0.
REQ-018 Stage 2 (execute): when s1 valid and (!oValid || iReady), ALU result and flags load into output registers, oValid set.
REQ-019 Latency: result presented 2 cycles after transfer cycle with no backpressure; throughput 1 per cycle.
REQ-020 oReady = !s1valid || stage-2 load this cycle; combinational, no dependence on iValid.
REQ-021 oValid held and oAccumulator/flags stable while oValid && !iReady; oValid clears on iReady with no new stage-2 load.
REQ-022 Opcodes: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B, 101 ~A, 110 A+1, 111 pass B.
REQ-023 Carry: ADD/INC carry-out of bit WIDTH-1; SUB = no-borrow (1 when A>=B unsigned); 0 for logic ops.
REQ-024 Overflow: two's-complement signed overflow for ADD/SUB/INC; 0 otherwise.
REQ-025 Zero = (result == 0); Neg = result[WIDTH-1]; all opcodes.
REQ-026 iUseAcc operand is oAccumulator value at stage-2 load, so back-to-back accumulate ops chain without stall.
REQ-027 Simultaneous iReady-consume and new stage-2 load: oValid stays 1, registers take new result.

Reset
REQ-028 iResetN low: operand registers, oAccumulator, all flags = 0; s1 valid = 0; oValid = 0; oReady = 1 one edge after release at latest.
REQ-029 Reset mid-operation discards in-flight requests; no result emitted for them.

Structure
REQ-030 Shared package alu_pkg holds opcode constants, shift-command bit positions, flag index constants.
REQ-031 One sub-module alu_barrel_shift (WIDTH, SHW params, combinational), instantiated twice for A and B.
REQ-032 ALU, handshake, and registers reside in alu_pipe_datapath; no latches, no gated clocks.

Verification
REQ-033 WIDTH=16, ADD A=0xFFFF B=0x0001 cmd 100 both -> 2 cycles later oAccumulator=0x0000, C=1, Z=1, N=0, V=0.
REQ-034 SUB A=0x8000 B=0x0001 -> 0x7FFF, C=1, V=1, N=0; SUB A=0x0001 B=0x0002 -> 0xFFFF, C=0, N=1.
REQ-035 iA=0x8001 cmd 011 (rotate left) amount 1, iB=0 cmd 100, opcode 011 -> 0x0003; cmd 001 (linear left) amount 1 -> 0x0002.
REQ-036 Stream ADD with iUseAcc=1, A=1, B ignored, 4 consecutive transfers from acc 0 -> results 1,2,3,4 on consecutive cycles.
REQ-037 Hold iReady=0 for 3 cycles with 3 requests offered -> exactly 2 accepted (oReady drops), first result stable; release -> results in order, none lost/duplicated.
REQ-038 Assert iResetN low with both stages full -> all outputs 0, oValid=0; after release next request yields fresh result after 2 cycles.
